// File: rtl/alu_op_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_op_sequencer_if
//  Description : Bundle of the handshake and bus signals around the ALU
//                operand/opcode sequencer. It carries the input triplet
//                port, the ALU drive/return bus, the result port and the
//                FIFO occupancy.
//                  slave  : seen by alu_op_sequencer (accepts triplets,
//                           drives the ALU, presents results)
//                  master : seen by the producer/consumer/ALU environment
//  Parameters  : DEPTH - FIFO entries, sets the fifo_count width
//  Revision    : 1.0 - initial release
// ============================================================================
interface alu_op_sequencer_if #(
    parameter int DEPTH = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    // Input triplet port
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_opcode;
    logic [7:0]       in_a;
    logic [7:0]       in_b;
    logic             in_fwd;

    // ALU drive / return
    logic [3:0]       alu_opcode;
    logic [7:0]       alu_a;
    logic [7:0]       alu_b;
    logic [7:0]       alu_result;

    // Result port
    logic             res_valid;
    logic             res_ready;
    logic [7:0]       res_data;
    logic [3:0]       res_opcode;

    // Status
    logic [CNT_W-1:0] fifo_count;

    modport slave (
        input  in_valid, in_opcode, in_a, in_b, in_fwd,
        input  alu_result,
        input  res_ready,
        output in_ready,
        output alu_opcode, alu_a, alu_b,
        output res_valid, res_data, res_opcode,
        output fifo_count
    );

    modport master (
        output in_valid, in_opcode, in_a, in_b, in_fwd,
        output alu_result,
        output res_ready,
        input  in_ready,
        input  alu_opcode, alu_a, alu_b,
        input  res_valid, res_data, res_opcode,
        input  fifo_count
    );
endinterface
`default_nettype wire

// File: rtl/alu_op_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : alu_op_sequencer
//  Description : Operand/opcode sequencer placed directly upstream of a
//                registered 8-bit ALU. {opcode, A, B} triplets are queued in
//                a DEPTH-entry FIFO and issued one at a time; the ALU inputs
//                are held stable until the result has been captured, and the
//                result is offered with its opcode on a valid/ready port.
//
//  Ports       : clk    - rising-edge clock, shared with the ALU
//                rst_n  - asynchronous active-low reset
//                bus    - alu_op_sequencer_if.slave
//                  in_valid/in_ready, in_opcode, in_a, in_b, in_fwd
//                  alu_opcode, alu_a, alu_b  (to ALU), alu_result (from ALU)
//                  res_valid/res_ready, res_data, res_opcode
//                  fifo_count (occupied entries)
//
//  Parameters  : DEPTH       - FIFO entries, power of two, 2..16
//                ALU_LATENCY - edges from ALU input change to ALU_Out, 1..4
//
//  Macro       : ALU_SEQ_FWD_EN - when defined, each entry carries in_fwd
//                and an entry with fwd=1 takes alu_a from the forward
//                register (last handshaken result) instead of its own A.
//
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_op_sequencer #(
    parameter int DEPTH       = 4,
    parameter int ALU_LATENCY = 1
) (
    input wire                clk,
    input wire                rst_n,
    alu_op_sequencer_if.slave bus
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;
    localparam int c_lat_w = $clog2(ALU_LATENCY + 1);

`ifdef ALU_SEQ_FWD_EN
    // Entry layout: {fwd, opcode[3:0], a[7:0], b[7:0]}
    localparam int c_entry_w = 21;
`else
    // Entry layout: {opcode[3:0], a[7:0], b[7:0]}
    localparam int c_entry_w = 20;
`endif

    localparam logic [c_cnt_w-1:0] c_full = c_cnt_w'(DEPTH);
    localparam logic [c_lat_w-1:0] c_lat  = c_lat_w'(ALU_LATENCY);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t                 state_q,      state_d;
    logic [c_lat_w-1:0]     cnt_q,        cnt_d;
    logic [c_ptr_w-1:0]     wr_ptr_q,     wr_ptr_d;
    logic [c_ptr_w-1:0]     rd_ptr_q,     rd_ptr_d;
    logic [c_cnt_w-1:0]     count_q,      count_d;
    logic [c_entry_w-1:0]   mem_q [DEPTH];
    logic [c_entry_w-1:0]   mem_d [DEPTH];
    logic [3:0]             alu_opcode_q, alu_opcode_d;
    logic [7:0]             alu_a_q,      alu_a_d;
    logic [7:0]             alu_b_q,      alu_b_d;
    logic                   res_valid_q,  res_valid_d;
    logic [7:0]             res_data_q,   res_data_d;
    logic [3:0]             res_opcode_q, res_opcode_d;
`ifdef ALU_SEQ_FWD_EN
    logic [7:0]             fwd_q,        fwd_d;
`endif

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic                   w_in_ready;
    logic                   w_empty;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_load;
    logic                   w_res_hs;
    logic [c_entry_w-1:0]   w_entry_in;
    logic [c_entry_w-1:0]   w_head;

    // in_ready depends on the registered occupancy only, so it never follows
    // res_ready combinationally and stays low on a pop edge while full.
    assign w_in_ready = (count_q != c_full);
    assign w_empty    = (count_q == '0);
    assign w_push     = bus.in_valid && w_in_ready;
    assign w_res_hs   = res_valid_q && bus.res_ready;
    assign w_head     = mem_q[rd_ptr_q];

`ifdef ALU_SEQ_FWD_EN
    assign w_entry_in = {bus.in_fwd, bus.in_opcode, bus.in_a, bus.in_b};
`else
    assign w_entry_in = {bus.in_opcode, bus.in_a, bus.in_b};
    // in_fwd has no meaning without forwarding; sink it explicitly.
    logic w_unused_fwd;
    assign w_unused_fwd = bus.in_fwd;
`endif

    // ------------------------------------------------------------------------
    // Issue FSM next-state and ALU/result register next values
    // ------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        alu_opcode_d = alu_opcode_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        res_valid_d  = res_valid_q;
        res_data_d   = res_data_q;
        res_opcode_d = res_opcode_q;
        w_load       = 1'b0;
`ifdef ALU_SEQ_FWD_EN
        fwd_d        = fwd_q;
`endif

        case (state_q)
            S_IDLE: begin
                // An entry pushed on the previous edge is visible here; the
                // FIFO has no fall-through path to the ALU.
                if (!w_empty) begin
                    w_load  = 1'b1;
                    cnt_d   = c_lat;
                    state_d = S_WAIT;
                end
            end

            S_WAIT: begin
                // cnt is loaded with ALU_LATENCY, so capture happens
                // ALU_LATENCY+1 edges after the load edge, once the
                // registered ALU has reflected the new inputs.
                if (cnt_q == '0) begin
                    res_data_d   = bus.alu_result;
                    res_opcode_d = alu_opcode_q;
                    res_valid_d  = 1'b1;
                    state_d      = S_HOLD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            S_HOLD: begin
                if (w_res_hs) begin
                    res_valid_d = 1'b0;
`ifdef ALU_SEQ_FWD_EN
                    // Updated before the load below so a chained entry issued
                    // on this same edge sees the result being handed off.
                    fwd_d = res_data_q;
`endif
                    if (!w_empty) begin
                        w_load  = 1'b1;
                        cnt_d   = c_lat;
                        state_d = S_WAIT;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // ALU inputs only move on a load edge; otherwise they hold.
        if (w_load) begin
            alu_opcode_d = w_head[19:16];
            alu_b_d      = w_head[7:0];
`ifdef ALU_SEQ_FWD_EN
            alu_a_d      = w_head[20] ? fwd_d : w_head[15:8];
`else
            alu_a_d      = w_head[15:8];
`endif
        end
    end

    // A pop is exactly a load of the head entry into the ALU registers.
    assign w_pop = w_load;

    // ------------------------------------------------------------------------
    // FIFO next state
    // ------------------------------------------------------------------------
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (w_push) begin
            mem_d[wr_ptr_q] = w_entry_in;
            // Pointer width is log2(DEPTH), so the increment wraps modulo DEPTH.
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end

        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        case ({w_push, w_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            alu_opcode_q <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            res_valid_q  <= 1'b0;
            res_data_q   <= '0;
            res_opcode_q <= '0;
`ifdef ALU_SEQ_FWD_EN
            fwd_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            alu_opcode_q <= alu_opcode_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            res_valid_q  <= res_valid_d;
            res_data_q   <= res_data_d;
            res_opcode_q <= res_opcode_d;
`ifdef ALU_SEQ_FWD_EN
            fwd_q        <= fwd_d;
`endif
        end
    end

    // ------------------------------------------------------------------------
    // Outputs (all registered or derived from registered occupancy)
    // ------------------------------------------------------------------------
    assign bus.in_ready   = w_in_ready;
    assign bus.alu_opcode = alu_opcode_q;
    assign bus.alu_a      = alu_a_q;
    assign bus.alu_b      = alu_b_q;
    assign bus.res_valid  = res_valid_q;
    assign bus.res_data   = res_data_q;
    assign bus.res_opcode = res_opcode_q;
    assign bus.fifo_count = count_q;

endmodule
`default_nettype wire
